bist_ch_sequencer: RTL

BIST_CH_SEQUENCER -- requirements
Module: bist_ch_sequencer

---
 rtl/bist_ch_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/bist_ch_sequencer.sv
// bist_ch_sequencer: UART-commanded BIST channel sequencer.
// Takes mask/duration commands, runs channels, reports sticky results.
module bist_ch_sequencer #(
   parameter int          NUM_CH  = 8,
   parameter int          CNT_W   = 32,
   parameter int unsigned DEF_RUN = 450_000_000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] ch_done,
   input  logic [NUM_CH-1:0] ch_err,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ARG,
      RUN,
      REPORT
   } state_t;

   localparam logic [7:0] CMD_S = 8'h53;
   localparam logic [7:0] CMD_T = 8'h54;
   localparam logic [7:0] CMD_X = 8'h58;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] HDR   = 8'hA5;

   localparam logic [CNT_W-1:0] DUR_RST = CNT_W'(DEF_RUN);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t state, state_d;

   logic [NUM_CH-1:0] ch_en_d;
   logic              busy_d;
   logic              tx_valid_d;
   logic [7:0]        tx_data_d;
   logic [2:0]        tx_idx, tx_idx_d;
   logic [CNT_W-1:0]  run_cnt, run_cnt_d;
   logic [CNT_W-1:0]  dur, dur_d;
   logic [NUM_CH-1:0] done_stk, done_d;
   logic [NUM_CH-1:0] err_stk, err_d;
   logic [15:0]       pass_cnt, pass_d;
   logic              rpt_pend, rpt_d;
   logic              arg_t, arg_t_d;
   logic [1:0]        arg_n, arg_n_d;
   logic [23:0]       arg_sh, arg_sh_d;
   logic [15:0]       tmo, tmo_d;

   logic [31:0]       arg_word;
   logic [CNT_W-1:0]  new_dur;
   logic [NUM_CH-1:0] new_mask;
   logic [7:0]        done8;
   logic [7:0]        err8;
   logic [7:0]        nxt_byte;
   logic              hit_done;

   assign arg_word = {rx_data, arg_sh};
   assign new_dur  = arg_word[CNT_W-1:0];
   assign new_mask = rx_data[NUM_CH-1:0];
   assign done8    = 8'(done_stk);
   assign err8     = 8'(err_stk);
   assign hit_done = |(ch_done & ch_en);

   // Report byte that follows the one currently on tx_data.
   always_comb begin
      case (tx_idx)
         3'd0:    nxt_byte = done8;
         3'd1:    nxt_byte = err8;
         3'd2:    nxt_byte = pass_cnt[15:8];
         default: nxt_byte = pass_cnt[7:0];
      endcase
   end

   // Next-state and next-register decode for the command sequencer.
   always_comb begin
      state_d    = state;
      ch_en_d    = ch_en;
      tx_valid_d = tx_valid;
      tx_data_d  = tx_data;
      tx_idx_d   = tx_idx;
      run_cnt_d  = run_cnt;
      dur_d      = dur;
      done_d     = done_stk | (ch_done & ch_en);
      err_d      = err_stk | (ch_err & ch_en);
      pass_d     = pass_cnt;
      rpt_d      = rpt_pend;
      arg_t_d    = arg_t;
      arg_n_d    = arg_n;
      arg_sh_d   = arg_sh;
      tmo_d      = tmo;
      if (hit_done && (pass_cnt != 16'hFFFF))
         pass_d = pass_cnt + 16'd1;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  CMD_S, CMD_T: begin
                     state_d = ARG;
                     arg_t_d = (rx_data == CMD_T);
                     arg_n_d = '0;
                     tmo_d   = '0;
                  end
                  CMD_R: begin
                     state_d = REPORT;
                     rpt_d   = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ARG: begin
            if (rx_valid) begin
               tmo_d    = '0;
               arg_sh_d = {rx_data, arg_sh[23:8]};
               arg_n_d  = arg_n + 2'd1;
               if (!arg_t) begin
                  ch_en_d   = new_mask;
                  run_cnt_d = '0;
                  done_d    = '0;
                  err_d     = '0;
                  pass_d    = '0;
                  state_d   = (new_mask != '0) ? RUN : IDLE;
               end else if (arg_n == 2'd3) begin
                  dur_d   = (new_dur == '0) ? ONE : new_dur;
                  state_d = IDLE;
               end
            end else if (tmo == 16'hFFFF) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo + 16'd1;
            end
         end
         RUN: begin
            run_cnt_d = run_cnt + ONE;
            if (rx_valid && (rx_data == CMD_R))
               rpt_d = 1'b1;
            if ((rx_valid && (rx_data == CMD_X)) ||
                (run_cnt == dur - ONE)) begin
               ch_en_d = '0;
               state_d = REPORT;
            end
         end
         REPORT: begin
            if (!tx_valid) begin
               if (rpt_pend) begin
                  tx_valid_d = 1'b1;
                  tx_data_d  = HDR;
                  tx_idx_d   = '0;
                  rpt_d      = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (tx_ready) begin
               if (tx_idx == 3'd4) begin
                  tx_valid_d = 1'b0;
                  tx_idx_d   = '0;
                  state_d    = IDLE;
               end else begin
                  tx_idx_d  = tx_idx + 3'd1;
                  tx_data_d = nxt_byte;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_d;
   end

   // Datapath registers: outputs, counters, sticky masks, arg capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ch_en    <= '0;
         busy     <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         tx_idx   <= '0;
         run_cnt  <= '0;
         dur      <= DUR_RST;
         done_stk <= '0;
         err_stk  <= '0;
         pass_cnt <= '0;
         rpt_pend <= 1'b0;
         arg_t    <= 1'b0;
         arg_n    <= '0;
         arg_sh   <= '0;
         tmo      <= '0;
      end else begin
         ch_en    <= ch_en_d;
         busy     <= busy_d;
         tx_valid <= tx_valid_d;
         tx_data  <= tx_data_d;
         tx_idx   <= tx_idx_d;
         run_cnt  <= run_cnt_d;
         dur      <= dur_d;
         done_stk <= done_d;
         err_stk  <= err_d;
         pass_cnt <= pass_d;
         rpt_pend <= rpt_d;
         arg_t    <= arg_t_d;
         arg_n    <= arg_n_d;
         arg_sh   <= arg_sh_d;
         tmo      <= tmo_d;
      end
   end

endmodule
